// File: rtl/hash_pkg.sv
// Shared constants, state encoding and datapath helpers for the multi-lane key hash.
// Helpers work on a fixed maximum beat width so callers of any FIFOWIDTH can share them.
package hash_pkg;

  localparam logic [31:0] GOLDEN    = 32'h9E3779B9;
  localparam int          KEY_MAX_W = 1024;
  localparam int          KEY_MAX_B = KEY_MAX_W / 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ABSORB = 2'd1;
  localparam logic [1:0] ST_FINAL  = 2'd2;
  localparam logic [1:0] ST_OUT    = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ABSORB = ST_ABSORB,
    FINAL  = ST_FINAL,
    OUT    = ST_OUT
  } state_t;

  function automatic logic [31:0] seed(input int unsigned idx);
    logic [31:0] mult;
    mult = 32'(idx + 1);
    return GOLDEN * mult;
  endfunction

  function automatic logic [31:0] rotl5(input logic [31:0] h);
    return {h[26:0], h[31:27]};
  endfunction

  // Words above the real beat width are zero, so they drop out of the XOR.
  function automatic logic [31:0] fold32(input logic [KEY_MAX_W-1:0] beat);
    logic [31:0] acc;
    acc = '0;
    for (int w = 0; w < KEY_MAX_W / 32; w++) begin
      acc = acc ^ beat[w*32 +: 32];
    end
    return acc;
  endfunction

  function automatic logic [KEY_MAX_B-1:0] byte_mask(input int unsigned len,
                                                     input int unsigned beat_idx,
                                                     input int unsigned bpb);
    logic [KEY_MAX_B-1:0] keep;
    keep = '0;
    for (int unsigned j = 0; j < KEY_MAX_B; j++) begin
      if ((j < bpb) && ((beat_idx * bpb + j) < len)) begin
        keep[j] = 1'b1;
      end
    end
    return keep;
  endfunction

endpackage

// File: rtl/hash_func_multi_if.sv
// FIFO-side bundle of the key hash stage: two FWFT read ports and one write port.
// A pop (o_rd_*_en) is only legal while the matching empty flag is low and the head word
// is consumed on that same clock edge; o_wr_hash_en is only legal while i_wr_hash_full is low.
interface hash_func_multi_if
  import hash_pkg::*;
#(
  parameter int FIFOWIDTH = 128,
  parameter int NUM_HASH  = 3,
  parameter int HASH_W    = 32
);

  logic                       o_rd_key_clk;
  logic                       i_rd_key_empty;
  logic                       i_rd_len_empty;
  logic                       o_rd_key_en;
  logic                       o_rd_len_en;
  logic [FIFOWIDTH-1:0]       i_key;
  logic [7:0]                 i_key_len;
  logic                       o_wr_hash_clk;
  logic                       i_wr_hash_full;
  logic                       o_wr_hash_en;
  logic [NUM_HASH*HASH_W-1:0] o_key_hash;
  logic                       o_len_err;
  state_t                     dbg_state;

  modport master (
    input  i_rd_key_empty, i_rd_len_empty, i_key, i_key_len, i_wr_hash_full,
    output o_rd_key_clk, o_rd_key_en, o_rd_len_en, o_wr_hash_clk, o_wr_hash_en,
           o_key_hash, o_len_err, dbg_state
  );

  modport slave (
    output i_rd_key_empty, i_rd_len_empty, i_key, i_key_len, i_wr_hash_full,
    input  o_rd_key_clk, o_rd_key_en, o_rd_len_en, o_wr_hash_clk, o_wr_hash_en,
           o_key_hash, o_len_err, dbg_state
  );

endinterface

// File: rtl/hash_lane.sv
// One seeded hash lane: seed load, per-beat rotate/XOR absorb, and a finalize step that
// mixes the high half down and keeps only the lane's effective width.
module hash_lane
  import hash_pkg::*;
#(
  parameter logic [31:0] SEED       = GOLDEN,
  parameter int          LANE_WIDTH = 32,
  parameter int          HASH_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              absorb,
  input  logic              finalize,
  input  logic [31:0]       fold,
  output logic [HASH_W-1:0] result
);

  localparam logic [31:0] LANE_MASK = (LANE_WIDTH >= 32) ? 32'hFFFF_FFFF
                                                         : ((32'd1 << LANE_WIDTH) - 32'd1);

  logic [31:0] h;
  logic [31:0] f;

  assign f = h ^ (h >> 16);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h      <= '0;
      result <= '0;
    end else begin
      if (load) begin
        h <= SEED;
      end else if (absorb) begin
        h <= rotl5(h) ^ fold;
      end
      if (finalize) begin
        result <= HASH_W'(f & LANE_MASK);
      end
    end
  end

endmodule

// File: rtl/hash_func_multi.sv
// Key hash stage: pops a length and a multi-beat key from FWFT FIFOs, masks bytes past the
// length, hashes every beat into NUM_HASH seeded lanes and pushes one packed result word.
module hash_func_multi
  import hash_pkg::*;
#(
  parameter int                    FIFOWIDTH = 128,
  parameter int                    MAX_BEATS = 4,
  parameter int                    NUM_HASH  = 3,
  parameter int                    HASH_W    = 32,
  parameter logic [8*NUM_HASH-1:0] LANE_W    = {8'd5, 8'd24, 8'd28}
) (
  input  logic               clk,
  input  logic               rst,
  hash_func_multi_if.master  bus
);

  localparam int BPB       = FIFOWIDTH / 8;
  localparam int CAP_BYTES = MAX_BEATS * BPB;
  localparam int LEN_W     = $clog2(CAP_BYTES + 1);
  localparam int BEAT_W    = $clog2(MAX_BEATS + 1);

  state_t                     state;
  logic [LEN_W-1:0]           len_q;
  logic [BEAT_W-1:0]          beats_q;
  logic [BEAT_W-1:0]          beat_idx;
  logic                       len_err_q;
  logic [NUM_HASH*HASH_W-1:0] hash_vec;

  logic                       len_pop;
  logic                       key_pop;
  logic                       hash_wr;
  logic                       last_beat;
  int unsigned                len_in;
  int unsigned                beats_in;
  logic                       clamp;
  logic [KEY_MAX_W-1:0]       key_wide;
  logic [KEY_MAX_W-1:0]       key_masked;
  logic [KEY_MAX_B-1:0]       keep;
  logic [31:0]                fold_val;

  // Pops and the write are decoded from the registered state so the FWFT head word is
  // consumed on the same edge that absorbs it; reset blanks them immediately.
  assign len_pop   = !rst && (state == IDLE)   && !bus.i_rd_len_empty;
  assign key_pop   = !rst && (state == ABSORB) && !bus.i_rd_key_empty;
  assign hash_wr   = !rst && (state == OUT)    && !bus.i_wr_hash_full;
  assign last_beat = (beat_idx == beats_q - 1'b1);

  always_comb begin
    len_in   = 32'(bus.i_key_len);
    beats_in = (len_in == 0) ? 1 : (len_in + BPB - 1) / BPB;
    clamp    = (beats_in > MAX_BEATS);
  end

  always_comb begin
    key_wide   = KEY_MAX_W'(bus.i_key);
    keep       = byte_mask(32'(len_q), 32'(beat_idx), BPB);
    key_masked = '0;
    for (int j = 0; j < KEY_MAX_B; j++) begin
      if (keep[j]) begin
        key_masked[j*8 +: 8] = key_wide[j*8 +: 8];
      end
    end
    fold_val = fold32(key_masked);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      beats_q   <= '0;
      beat_idx  <= '0;
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (len_pop) begin
            len_q     <= clamp ? LEN_W'(CAP_BYTES) : LEN_W'(len_in);
            beats_q   <= clamp ? BEAT_W'(MAX_BEATS) : BEAT_W'(beats_in);
            beat_idx  <= '0;
            len_err_q <= clamp;
            state     <= ABSORB;
          end
        end
        ABSORB: begin
          if (key_pop) begin
            if (last_beat) begin
              state <= FINAL;
            end else begin
              beat_idx <= beat_idx + 1'b1;
            end
          end
        end
        FINAL: begin
          state <= OUT;
        end
        OUT: begin
          if (!bus.i_wr_hash_full) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_HASH; i++) begin : g_lane
    hash_lane #(
      .SEED       (seed(i)),
      .LANE_WIDTH (int'(LANE_W[8*i +: 8])),
      .HASH_W     (HASH_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (len_pop),
      .absorb   (key_pop),
      .finalize (state == FINAL),
      .fold     (fold_val),
      .result   (hash_vec[i*HASH_W +: HASH_W])
    );
  end

  assign bus.o_rd_key_clk  = clk;
  assign bus.o_wr_hash_clk = clk;
  assign bus.o_rd_len_en   = len_pop;
  assign bus.o_rd_key_en   = key_pop;
  assign bus.o_wr_hash_en  = hash_wr;
  assign bus.o_key_hash    = hash_vec;
  assign bus.o_len_err     = len_err_q;
  assign bus.dbg_state     = state;

endmodule

// File: tb/tb_hash_func_multi.sv
// Directed bench for hash_func_multi: FWFT FIFO models, event counters and hand-computed
// lane results for zero, all-ones, short, empty, multi-beat, clamped and back-pressured keys.
module tb_hash_func_multi;
  import hash_pkg::*;

  localparam int FW = 128;
  localparam int NH = 3;
  localparam int HW = 32;
  localparam logic [95:0] EXP_ZERO = {32'h0000_0016, 32'h00DE_E399, 32'h06EF_F1DC};
  localparam logic [FW-1:0] ONES = '1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_stall = 1'b0;
  logic full = 1'b0;

  hash_func_multi_if #(.FIFOWIDTH(FW), .NUM_HASH(NH), .HASH_W(HW)) bus ();

  hash_func_multi #(
    .FIFOWIDTH (FW),
    .MAX_BEATS (4),
    .NUM_HASH  (NH),
    .HASH_W    (HW),
    .LANE_W    ({8'd5, 8'd24, 8'd28})
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // FWFT FIFO models: pointers advance 1 time unit after the edge that consumed the head.
  logic [7:0]    len_mem [0:15];
  logic [FW-1:0] key_mem [0:15];
  logic [4:0]    len_wr = '0, len_rd = '0, key_wr = '0, key_rd = '0;

  assign bus.i_rd_len_empty = (len_rd == len_wr);
  assign bus.i_key_len      = len_mem[len_rd[3:0]];
  assign bus.i_rd_key_empty = (key_rd == key_wr) || key_stall;
  assign bus.i_key          = key_mem[key_rd[3:0]];
  assign bus.i_wr_hash_full = full;

  int   cyc = 0, len_pops = 0, key_pops = 0, writes = 0, errs = 0, viol = 0;
  int   len_pop_cyc = 0, key_pop_cyc = 0, wr_cyc = 0;
  logic len_pend = 1'b0, key_pend = 1'b0;

  always @(negedge clk) begin
    cyc++;
    len_pend = bus.o_rd_len_en;
    key_pend = bus.o_rd_key_en;
    if (bus.o_rd_len_en) begin len_pops++; len_pop_cyc = cyc; end
    if (bus.o_rd_key_en) begin key_pops++; key_pop_cyc = cyc; end
    if (bus.o_wr_hash_en) begin writes++; wr_cyc = cyc; end
    if (bus.o_len_err) errs++;
    if ((bus.o_rd_len_en && bus.i_rd_len_empty) || (bus.o_rd_key_en && bus.i_rd_key_empty) ||
        (bus.o_rd_len_en && bus.o_rd_key_en) || (bus.o_wr_hash_en && full)) viol++;
  end

  always @(posedge clk) begin
    #1;
    if (len_pend) len_rd = len_rd + 5'd1;
    if (key_pend) key_rd = key_rd + 5'd1;
  end

  int tests = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_point();
    @(posedge clk);
    #2;
  endtask

  task automatic sample_point();
    @(negedge clk);
    #1;
  endtask

  task automatic push_len(input logic [7:0] l);
    len_mem[len_wr[3:0]] = l;
    len_wr = len_wr + 5'd1;
  endtask

  task automatic push_key(input logic [FW-1:0] k);
    key_mem[key_wr[3:0]] = k;
    key_wr = key_wr + 5'd1;
  endtask

  task automatic wait_write(input string tag);
    int target;
    target = writes + 1;
    for (int i = 0; i < 60; i++) begin
      if (writes >= target) break;
      sample_point();
    end
    check(tag, writes, target);
  endtask

  task automatic wait_key_pops(input string tag, input int target);
    for (int i = 0; i < 40; i++) begin
      if (key_pops >= target) break;
      sample_point();
    end
    check(tag, key_pops, target);
  endtask

  task automatic wait_state(input string tag, input state_t st);
    for (int i = 0; i < 40; i++) begin
      if (bus.dbg_state == st) break;
      sample_point();
    end
    check(tag, bus.dbg_state, st);
  endtask

  int base_keys, base_lens, base_errs, base_wr;

  initial begin
    for (int i = 0; i < 16; i++) begin
      len_mem[i] = '0;
      key_mem[i] = '0;
    end

    // Reset state, with a length already waiting that must not be popped.
    push_len(8'd16);
    push_key('0);
    repeat (3) sample_point();
    check("rst_state", bus.dbg_state, IDLE);
    check("rst_hash", bus.o_key_hash, 96'h0);
    check("rst_strobes", {bus.o_rd_len_en, bus.o_rd_key_en, bus.o_wr_hash_en, bus.o_len_err}, 4'b0);
    check("rst_no_pops", len_pops + key_pops, 0);

    // Single all-zero beat, latency from length pop to write.
    drive_point();
    rst = 1'b0;
    wait_write("s1_write");
    check("s1_key_lat", key_pop_cyc - len_pop_cyc, 1);
    check("s1_wr_lat", wr_cyc - len_pop_cyc, 3);
    check("s1_hash", bus.o_key_hash, EXP_ZERO);
    check("s1_pops", {len_pops[7:0], key_pops[7:0]}, 16'h0101);

    // All-ones 16-byte beat folds to zero.
    drive_point();
    push_len(8'd16);
    push_key(ONES);
    wait_write("s2_write");
    check("s2_hash", bus.o_key_hash, EXP_ZERO);

    // Short key: only bytes 0..3 survive the mask.
    drive_point();
    push_len(8'd4);
    push_key(ONES);
    wait_write("s3a_write");
    check("s3a_lane0", bus.o_key_hash[27:0], 28'h910F1DC);

    // Zero-length key consumes exactly one fully masked beat.
    base_keys = key_pops;
    drive_point();
    push_len(8'd0);
    push_key(ONES);
    wait_write("s3b_write");
    check("s3b_lane0", bus.o_key_hash[27:0], 28'h6EFF1DC);
    check("s3b_key_pops", key_pops - base_keys, 1);

    // Three-beat key with the key FIFO starved between beats 1 and 2.
    base_keys = key_pops;
    base_wr = writes;
    drive_point();
    push_len(8'd40);
    push_key(ONES);
    push_key(ONES);
    wait_key_pops("s4_two_beats", base_keys + 2);
    drive_point();
    key_stall = 1'b1;
    push_key(ONES);
    repeat (5) sample_point();
    check("s4_stall_pops", key_pops - base_keys, 2);
    check("s4_stall_no_wr", writes - base_wr, 0);
    check("s4_stall_state", bus.dbg_state, ABSORB);
    drive_point();
    key_stall = 1'b0;
    wait_write("s4_write");
    check("s4_key_pops", key_pops - base_keys, 3);
    check("s4_lane0", bus.o_key_hash[27:0], 28'hCDC73C7);

    // Over-long key is clamped to four beats.
    base_keys = key_pops;
    base_lens = len_pops;
    base_errs = errs;
    drive_point();
    push_len(8'd200);
    for (int b = 0; b < 4; b++) push_key(ONES);
    wait_write("s5_write");
    check("s5_len_err", errs - base_errs, 1);
    check("s5_key_pops", key_pops - base_keys, 4);
    check("s5_len_pops", len_pops - base_lens, 1);
    check("s5_lane0", bus.o_key_hash[27:0], 28'hB9978EE);

    // Downstream full while the result waits in OUT.
    drive_point();
    full = 1'b1;
    push_len(8'd16);
    push_key('0);
    wait_state("s6_reach_out", OUT);
    base_wr = writes;
    repeat (10) sample_point();
    check("s6_hold_hash", bus.o_key_hash, EXP_ZERO);
    check("s6_hold_no_wr", writes - base_wr, 0);
    check("s6_hold_state", bus.dbg_state, OUT);
    drive_point();
    full = 1'b0;
    sample_point();
    check("s6_wr_on_release", bus.o_wr_hash_en, 1'b1);
    sample_point();
    check("s6_one_write", writes - base_wr, 1);
    check("s6_back_idle", bus.dbg_state, IDLE);

    // Reset in the middle of a three-beat key.
    base_keys = key_pops;
    base_wr = writes;
    drive_point();
    push_len(8'd48);
    push_key(ONES);
    wait_key_pops("s7_first_beat", base_keys + 1);
    drive_point();
    rst = 1'b1;
    sample_point();
    check("s7_rst_state", bus.dbg_state, IDLE);
    check("s7_rst_hash", bus.o_key_hash, 96'h0);
    check("s7_rst_strobes", {bus.o_rd_len_en, bus.o_rd_key_en, bus.o_wr_hash_en, bus.o_len_err}, 4'b0);
    repeat (4) sample_point();
    check("s7_rst_no_wr", writes - base_wr, 0);
    check("s7_rst_no_pops", key_pops - base_keys, 1);
    drive_point();
    rst = 1'b0;
    push_len(8'd4);
    push_key(ONES);
    wait_write("s7_recover_write");
    check("s7_recover_lane0", bus.o_key_hash[27:0], 28'h910F1DC);

    check("protocol_violations", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/hash_func_multi.md
Name: hash_func_multi

Overview:
Parametrised successor to the key-hash stage. It pops a key length and a multi-beat key from first-word-fall-through (FWFT) upstream FIFOs. It masks bytes beyond the key length and absorbs each beat into NUM_HASH independent seeded hash lanes. It then writes one packed hash word per key into the downstream hash FIFO, and sits between the key FIFOs and the hash-table address stage.

Parameters:
FIFOWIDTH, 128, key beat width in bits; must be a multiple of 32.
MAX_BEATS, 4, maximum beats per key; the length cap is MAX_BEATS*FIFOWIDTH/8 bytes.
NUM_HASH, 3, number of hash lanes.
HASH_W, 32, output slot width per lane; must be ≤ 32.
LANE_W, {8'd5,8'd24,8'd28}, packed 8-bit effective widths; lane i width is LANE_W[8i+:8] and must be ≤ HASH_W.

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-high.
o_rd_key_clk  out  1  equals clk; forwarded to upstream FIFO read clock.
i_rd_key_empty  in  1  key FIFO empty.
i_rd_len_empty  in  1  length FIFO empty.
o_rd_key_en  out  1  key FIFO pop; one-cycle pulse.
o_rd_len_en  out  1  length FIFO pop; one-cycle pulse.
i_key  in  FIFOWIDTH  FWFT key beat; byte 0 is bits [7:0].
i_key_len  in  8  key length in bytes.
o_wr_hash_clk  out  1  equals clk.
i_wr_hash_full  in  1  hash FIFO full.
o_wr_hash_en  out  1  hash FIFO write; one-cycle pulse.
o_key_hash  out  NUM_HASH*HASH_W  lane i result in slot [i*HASH_W +: HASH_W], zero-extended above LANE_W(i).
o_len_err  out  1  one-cycle pulse when a length is clamped.

Behaviour:
- Reset: the async assert forces state IDLE. All pops and writes are 0; o_key_hash=0; o_len_err=0; internal lane state and counters are 0.
- Reset mid-key: any partial key is discarded with no write. After deassert, the block restarts at IDLE and re-reads the next length.
- The FSM has four states: IDLE, ABSORB, FINAL and OUT.
- IDLE:
  - Waits for !i_rd_len_empty.
  - Then asserts o_rd_len_en for 1 cycle and latches the length.
  - beats = max(1, ceil(len/BPB)) with BPB=FIFOWIDTH/8; len=0 consumes one fully masked beat.
  - If beats > MAX_BEATS: clamp to MAX_BEATS, mask to MAX_BEATS*BPB bytes, pulse o_len_err.
  - Lane state h_i is loaded with SEED_i; then go to ABSORB.
- ABSORB:
  - Each cycle with !i_rd_key_empty: assert o_rd_key_en, mask i_key, and update every lane.
  - With empty asserted: stall with no pop and no state change.
  - After the last beat, go to FINAL. Any extra upstream beats for a clamped key are NOT consumed; the producer must not send them.
- Masking: byte j of beat b is kept iff b*BPB+j < len; otherwise it is zeroed.
- Fold: XOR of the FIFOWIDTH/32 32-bit words of the masked beat.
- Lane update: h_i <= rotl(h_i,5) ^ fold. Lanes differ only by seed.
- SEED_i = (32'h9E3779B9 * (i+1)) mod 2^32.
- FINAL: f_i = h_i ^ (h_i >> 16). The result register is set to f_i[LANE_W(i)-1:0] zero-extended; go to OUT.
- OUT:
  - While i_wr_hash_full, hold o_key_hash stable with o_wr_hash_en=0.
  - When not full, pulse o_wr_hash_en for 1 cycle and go to IDLE. o_key_hash holds its value until the next FINAL.
- Latency: for an uncontended single-beat key, the length pop is at cycle 0, the key pop at cycle 1, FINAL at cycle 2, and the write at cycle 3.
  - Throughput is one key per beats+3 cycles.
- Length and key pops never occur in the same cycle, and a pop never occurs while the corresponding empty flag is high.

Decomposition:
- Package hash_pkg holds:
  - the constant GOLDEN=32'h9E3779B9 and the seed function seed(i);
  - functions rotl5, fold32(beat) and byte_mask(len, beat_idx);
  - the FSM state encoding localparams.
- One sub-module, hash_lane: holds h, with load-seed, absorb and finalize, plus the width truncation.
- The top level instantiates NUM_HASH hash_lane instances via generate and holds the FSM, beat counter and mask.

Test Plan:
1. Reset, then len=16 with one all-zero beat and the FIFO not full -> single write at cycle 3 after the length pop; lane0 (28b) = 0x6EFF1DC.
2. len=16 with the beat all-ones -> the fold is 0, so lane0 = 0x6EFF1DC, identical to scenario 1.
3. len=4 with the beat all-ones (bytes 4..15 masked) -> lane0 = 0x910F1DC; len=0 with the beat all-ones -> lane0 = 0x6EFF1DC and exactly one key pop.
4. len=40 with 3 beats, and i_rd_key_empty high for 5 cycles between beats 1 and 2 -> exactly 3 key pops, no pop while empty, one write.
5. len=200 (cap 64) -> o_len_err pulses once, exactly 4 key pops, one write.
6. i_wr_hash_full held high for 10 cycles in OUT -> o_key_hash stable and no write; the write occurs the cycle after full drops. Assert rst during ABSORB -> no write, pops stop, all outputs 0.
